// File: rtl/elevator_scan_ctrl_if.sv
// elevator_scan_ctrl_if: request/indicator bundle between the call-button
// decode (master) and the elevator controller (slave).
// door_hold exists only when ELEV_DOOR_HOLD_EN is defined.
interface elevator_scan_ctrl_if #(
  parameter int NUM_FLOORS = 8
);
  localparam int FLOOR_W = $clog2(NUM_FLOORS);

  logic [NUM_FLOORS-1:0] req_set;
  logic [FLOOR_W-1:0]    floor_pos;
  logic                  dir_up;
  logic                  moving;
  logic                  door_open;
  logic                  arrived;
  logic [NUM_FLOORS-1:0] pending;
`ifdef ELEV_DOOR_HOLD_EN
  logic                  door_hold;
`endif

  modport master (
`ifdef ELEV_DOOR_HOLD_EN
    output door_hold,
`endif
    output req_set,
    input  floor_pos, dir_up, moving, door_open, arrived, pending
  );

  modport slave (
`ifdef ELEV_DOOR_HOLD_EN
    input  door_hold,
`endif
    input  req_set,
    output floor_pos, dir_up, moving, door_open, arrived, pending
  );
endinterface

// File: rtl/elevator_scan_ctrl.sv
// elevator_scan_ctrl: N-floor elevator controller. Requests are latched in a
// pending bitmap and served in SCAN order (keep direction while requests lie
// ahead, reverse only when none remain). Travel and door are timed.
// Optional feature macro: ELEV_DOOR_HOLD_EN (door_hold keeps the door open).
//
// state | meaning
// IDLE  | one-cycle decision: open door here, move toward a request, or wait
// MOVE  | travelling one floor step for TRAVEL_CYCLES cycles
// DOOR  | door open, timer counts down to close
module elevator_scan_ctrl #(
  parameter int NUM_FLOORS    = 8,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 8
) (
  input logic                 clk,
  input logic                 reset_n,
  elevator_scan_ctrl_if.slave bus
);
  localparam int FLOOR_W = $clog2(NUM_FLOORS);
  localparam int TRAV_W  = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DOOR_W  = $clog2(DOOR_CYCLES + 1);
  localparam logic [TRAV_W-1:0] TRAV_LAST = TRAV_W'(TRAVEL_CYCLES - 1);
  localparam logic [DOOR_W-1:0] DOOR_LOAD = DOOR_W'(DOOR_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR} state_t;

  state_t                state_q, state_d;
  logic [FLOOR_W-1:0]    floor_q, floor_d;
  logic                  dir_q, dir_d;
  logic                  arrived_q, arrived_d;
  logic [NUM_FLOORS-1:0] pend_q, pend_d;
  logic [TRAV_W-1:0]     trav_q, trav_d;
  logic [DOOR_W-1:0]     door_q, door_d;

  logic                  above, below, ahead, behind;
  logic                  hold, here_req;
  logic [NUM_FLOORS-1:0] here_mask, clr, req_eff;

`ifdef ELEV_DOOR_HOLD_EN
  assign hold = bus.door_hold;
`else
  assign hold = 1'b0;
`endif

  assign here_mask = NUM_FLOORS'(1) << floor_q;
  assign here_req  = |(bus.req_set & here_mask);
  assign ahead     = dir_q ? above : below;
  assign behind    = dir_q ? below : above;

  // Is any pending request above / below the current floor?
  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pend_q[i] && (FLOOR_W'(i) > floor_q)) above = 1'b1;
      if (pend_q[i] && (FLOOR_W'(i) < floor_q)) below = 1'b1;
    end
  end

  // Next-state: SCAN decision, travel/door timers, request bitmap.
  always_comb begin
    state_d   = state_q;
    floor_d   = floor_q;
    dir_d     = dir_q;
    arrived_d = 1'b0;
    trav_d    = trav_q;
    door_d    = door_q;
    clr       = '0;
    req_eff   = bus.req_set;
    case (state_q)
      S_IDLE: begin
        if (|pend_q) begin
          if (|(pend_q & here_mask)) begin
            state_d = S_DOOR;
            door_d  = DOOR_LOAD;
            clr     = here_mask;
          end else if (ahead) begin
            state_d = S_MOVE;
            trav_d  = '0;
          end else if (behind) begin
            state_d = S_MOVE;
            trav_d  = '0;
            dir_d   = ~dir_q;
          end
        end
      end
      S_MOVE: begin
        if (trav_q == TRAV_LAST) begin
          state_d   = S_IDLE;
          trav_d    = '0;
          floor_d   = dir_q ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
          arrived_d = 1'b1;
        end else begin
          trav_d = trav_q + TRAV_W'(1);
        end
      end
      S_DOOR: begin
        // A call for the floor we are standing at just keeps the door open.
        req_eff = bus.req_set & ~here_mask;
        if (hold || here_req) begin
          door_d = DOOR_LOAD;
        end else if (door_q == DOOR_W'(1)) begin
          state_d = S_IDLE;
          door_d  = '0;
        end else begin
          door_d = door_q - DOOR_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    pend_d = (pend_q | req_eff) & ~clr;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      floor_q   <= '0;
      dir_q     <= 1'b1;
      arrived_q <= 1'b0;
      pend_q    <= '0;
      trav_q    <= '0;
      door_q    <= '0;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      dir_q     <= dir_d;
      arrived_q <= arrived_d;
      pend_q    <= pend_d;
      trav_q    <= trav_d;
      door_q    <= door_d;
    end
  end

  assign bus.floor_pos = floor_q;
  assign bus.dir_up    = dir_q;
  assign bus.moving    = (state_q == S_MOVE);
  assign bus.door_open = (state_q == S_DOOR);
  assign bus.arrived   = arrived_q;
  assign bus.pending   = pend_q;
endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Bench for elevator_scan_ctrl (8 floors, travel 4, door 8): directed
// scenarios with literal expectations plus randomized calls, all checked
// every cycle against a behavioural elevator model.
module tb_elevator_scan_ctrl;
  localparam int NF = 8;
  localparam int TC = 4;
  localparam int DC = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic hold_v = 1'b0;
  int   total = 0;
  int   bad = 0;

  elevator_scan_ctrl_if #(.NUM_FLOORS(NF)) bus ();
`ifdef ELEV_DOOR_HOLD_EN
  assign bus.door_hold = hold_v;
`endif

  elevator_scan_ctrl #(
    .NUM_FLOORS(NF), .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;

  // behavioural model: mode 0=waiting, 1=travelling, 2=door open
  int       m_mode, m_floor, m_left;
  bit       m_up, m_arr;
  bit [7:0] m_pend;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_floor = 0; m_left = 0; m_up = 1; m_arr = 0; m_pend = 0;
  endtask

  task automatic model_step(input bit [7:0] req, input bit hold);
    bit [7:0] old, nreq;
    bit       up_has, dn_has;
    old  = m_pend;
    nreq = req;
    m_arr = 0;
    case (m_mode)
      0: if (old != 0) begin
        if (old[m_floor]) begin
          m_mode = 2; m_left = DC;
          old[m_floor] = 0; nreq[m_floor] = 0;
        end else begin
          up_has = |(old >> (m_floor + 1));
          dn_has = |(old & 8'((1 << m_floor) - 1));
          if (!(m_up ? up_has : dn_has)) m_up = !m_up;
          m_mode = 1; m_left = TC;
        end
      end
      1: begin
        m_left--;
        if (m_left == 0) begin
          m_floor = m_up ? m_floor + 1 : m_floor - 1;
          m_arr = 1; m_mode = 0;
        end
      end
      default: begin
        if (nreq[m_floor] || hold) m_left = DC;
        else begin
          m_left--;
          if (m_left == 0) m_mode = 0;
        end
        nreq[m_floor] = 0;
      end
    endcase
    m_pend = old | nreq;
  endtask

  task automatic compare_all();
    chk("floor_pos", bus.floor_pos, m_floor);
    chk("dir_up", bus.dir_up, m_up);
    chk("moving", bus.moving, m_mode == 1);
    chk("door_open", bus.door_open, m_mode == 2);
    chk("arrived", bus.arrived, m_arr);
    chk("pending", bus.pending, m_pend);
  endtask

  // One clock: drive request, model the edge, compare on the falling edge.
  task automatic cycle(input logic [7:0] req);
    bus.req_set = req;
    @(posedge clk);
    model_step(req, hold_v);
    @(negedge clk);
    bus.req_set = '0;
    compare_all();
  endtask

  task automatic async_reset();
    #3 reset_n = 1'b0;
    model_reset();
    #1 compare_all();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int n, k, arr_cnt;
    bit prev_open;
    int stops[$];
    int stop_dir[$];
    bit [7:0] r;

    bus.req_set = '0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    chk("reset_floor", bus.floor_pos, 0);
    chk("reset_dir", bus.dir_up, 1);
    chk("reset_pending", bus.pending, 0);
    reset_n = 1'b1;
    cycle(8'h00);

    // 1: call at floor 0 -> door open exactly 8 cycles
    cycle(8'h01);
    chk("t1_pending_latched", bus.pending, 8'h01);
    n = 0;
    repeat (20) begin cycle(8'h00); n += int'(bus.door_open); end
    chk("t1_door_cycles", n, 8);
    chk("t1_pending_clear", bus.pending, 0);
    chk("t1_floor", bus.floor_pos, 0);

    // 2: call floor 5 -> arrives 25 cycles later, 5 arrived pulses
    cycle(8'h20);
    k = 0; arr_cnt = 0;
    while (bus.floor_pos != 3'd5 && k < 60) begin
      cycle(8'h00); k++; arr_cnt += int'(bus.arrived);
    end
    chk("t2_travel_cycles", k, 25);
    chk("t2_arrived_pulses", arr_cnt, 5);
    n = 0;
    repeat (20) begin cycle(8'h00); n += int'(bus.door_open); end
    chk("t2_door_cycles", n, 8);
    chk("t2_pending_clear", bus.pending, 0);

    // 4: door at floor 2, re-call with 3 cycles left -> 8 more cycles open
    cycle(8'h04);
    k = 0;
    while (!bus.door_open && k < 40) begin cycle(8'h00); k++; end
    chk("t4_door_floor", bus.floor_pos, 2);
    repeat (5) cycle(8'h00);
    cycle(8'h04);
    chk("t4_pending2_clear", bus.pending[2], 0);
    n = int'(bus.door_open);
    repeat (20) begin cycle(8'h00); n += int'(bus.door_open); end
    chk("t4_reload_cycles", n, 8);

    // 3: at floor 3 heading up, calls 1 and 6 -> stop at 6, then 1
    cycle(8'h08);
    k = 0;
    while (!bus.door_open && k < 30) begin cycle(8'h00); k++; end
    chk("t3_start_floor", bus.floor_pos, 3);
    chk("t3_start_dir", bus.dir_up, 1);
    cycle(8'h42);
    prev_open = bus.door_open;
    k = 0;
    while (k < 200 && !(stops.size() >= 2 && !bus.door_open)) begin
      cycle(8'h00); k++;
      if (bus.door_open && !prev_open) begin
        stops.push_back(int'(bus.floor_pos));
        stop_dir.push_back(int'(bus.dir_up));
      end
      prev_open = bus.door_open;
    end
    chk("t3_stop_count", stops.size(), 2);
    chk("t3_first_stop", stops.size() > 0 ? stops[0] : 99, 6);
    chk("t3_second_stop", stops.size() > 1 ? stops[1] : 99, 1);
    chk("t3_second_dir", stop_dir.size() > 1 ? stop_dir[1] : 99, 0);
    chk("t3_pending_clear", bus.pending, 0);

    // 5: async reset while moving at floor 4
    cycle(8'h80);
    k = 0;
    while (!(bus.floor_pos == 3'd4 && bus.moving) && k < 60) begin cycle(8'h00); k++; end
    chk("t5_mid_move", bus.moving, 1);
    async_reset();
    chk("t5_floor", bus.floor_pos, 0);
    chk("t5_pending", bus.pending, 0);
    chk("t5_moving", bus.moving, 0);
    chk("t5_dir", bus.dir_up, 1);
    n = 0;
    repeat (10) begin cycle(8'h00); n += int'(bus.moving) + int'(bus.door_open); end
    chk("t5_stays_idle", n, 0);

`ifdef ELEV_DOOR_HOLD_EN
    // 6: door_hold keeps the door open, closes 8 cycles after release
    cycle(8'h01);
    k = 0;
    while (!bus.door_open && k < 10) begin cycle(8'h00); k++; end
    hold_v = 1'b1;
    n = 0;
    repeat (20) begin cycle(8'h00); n += int'(bus.door_open); end
    chk("t6_held_open", n, 20);
    hold_v = 1'b0;
    k = 0;
    while (bus.door_open && k < 30) begin cycle(8'h00); k++; end
    chk("t6_close_after_release", k, 8);
`endif

    // randomized calls, one async reset mid-run
    for (int i = 0; i < 2500; i++) begin
      r = 8'h00;
      if ($urandom_range(0, 5) == 0) r = 8'($urandom) & 8'($urandom);
`ifdef ELEV_DOOR_HOLD_EN
      hold_v = ($urandom_range(0, 15) == 0);
`endif
      if (i == 1300) async_reset();
      cycle(r);
    end
    hold_v = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
